router_pkt_tx: RTL and testbench
================================

Name: router_pkt_tx

Overview:
- Packet source for the 1x3 router input port.
- Accepts a transfer request (destination address, payload length) and a payload byte stream from upstream, and buffers the whole payload internally.
- Then transmits header, payload and parity bytes to the router as one contiguous burst, honouring router busy.
- Samples the router parity-error flag after each packet, counts errors, and enforces an inter-packet gap.

Parameters:
GAP_CYC, 2, idle cycles after the parity byte before the next request is accepted (range 1..15); router err is sampled during these cycles
ERR_CNT_W, 8, width of saturating parity-error counter

Ports:
clk  input  1  clock
rst  input  1  synchronous, active-low reset
req_valid  input  1  request present
req_addr  input  2  destination port 0..2; 3 is illegal
req_len  input  6  payload bytes, 1..63; 0 is illegal
req_ready  output  1  request accepted on edge where req_valid&&req_ready
pld_valid  input  1  payload byte present
pld_data  input  8  payload byte
pld_ready  output  1  payload byte accepted on edge where pld_valid&&pld_ready
busy  input  1  router busy; hold current byte while high
err  input  1  router parity error indication
data_out  output  8  byte to router
pkt_valid  output  1  high for header and payload bytes, low for parity byte
pkt_done  output  1  one-cycle pulse at end of gap for every transmitted packet
req_err  output  1  one-cycle pulse when an illegal request is dropped
err_cnt  output  ERR_CNT_W  saturating count of packets flagged by err

Behaviour:
- Reset (rst low at edge) forces all of the following; an in-flight packet is abandoned with no parity byte sent:
  - state IDLE; data_out=0, pkt_valid=0, pld_ready=0, pkt_done=0, req_err=0, err_cnt=0
  - buffer write/read pointers 0; parity register 0
- All outputs are registered except req_ready=(state==IDLE) and pld_ready=(state==LOAD).
- States: IDLE, LOAD, HDR, PLD, PAR, GAP.
- IDLE:
  - On request handshake with req_addr==3 or req_len==0: req_err pulses next cycle, stay IDLE, nothing sent.
  - Otherwise latch addr/len, header H={req_len,req_addr}, parity P=H, write pointer 0, go LOAD.
- LOAD:
  - Each payload handshake writes pld_data into a 64x8 buffer at the write pointer, P^=pld_data, write pointer +1.
  - After the len-th byte is accepted, go HDR. No bubbles are sent to the router; underrun stalls only LOAD.
- HDR: data_out=H, pkt_valid=1. On an edge with busy=0, go PLD with read pointer 0.
- PLD:
  - data_out=buf[read pointer], pkt_valid=1.
  - Each edge with busy=0 advances the read pointer. After byte len-1 advances, go PAR.
  - While busy=1: data_out and pkt_valid hold; no advance.
- PAR: data_out=P, pkt_valid=0. On an edge with busy=0, go GAP.
- GAP:
  - data_out=0, pkt_valid=0. Count GAP_CYC cycles.
  - If err=1 on any GAP cycle, err_cnt increments once for that packet and saturates at all-ones.
  - On the last gap cycle pkt_done pulses and state returns to IDLE.
- busy on the edge entering HDR: the header is still presented; it is held until busy=0.
- Burst length on the router side is 1+len cycles with pkt_valid=1, followed by 1 parity cycle, not counting busy stalls.
- err outside GAP is ignored.
- Back-to-back requests: the earliest next req_ready is the cycle after pkt_done.

Optional Feature:
- Macro PKT_TX_PAR_INJECT_EN.
- Defined:
  - Adds input port inj_par (1 bit), sampled at request acceptance.
  - If it was 1, the parity byte sent in PAR is ~P, for forcing router err.
- Not defined: no inj_par port; the parity byte is always P.

Test Plan:
- Request addr=1, len=3, payload A0,B1,C2, busy=0 -> router sees 0x0D(pv=1), A0,B1,C2 (pv=1), parity 0x0D^A0^B1^C2=0xDE (pv=0); pkt_done pulses GAP_CYC cycles after parity.
- Same packet with busy=1 for 4 cycles while byte B1 is presented -> B1 is held stable for 5 cycles, then C2; no byte is skipped or duplicated.
- Request addr=3, len=5, then addr=0, len=0 -> two req_err pulses, pkt_valid never asserted, pld_ready never asserted.
- Request len=63 with pld_valid toggling 1/0 -> LOAD takes 125 cycles; the router burst is 64 consecutive pkt_valid cycles with no gaps.
- err=1 during GAP on 3 packets and at 256 more with ERR_CNT_W=8 -> err_cnt=3, then saturates at 255.
- rst=0 mid-PLD -> next cycle pkt_valid=0, data_out=0, state IDLE, err_cnt=0. With PKT_TX_PAR_INJECT_EN and inj_par=1 -> parity byte is inverted.

Source files
------------

// File: rtl/router_pkt_tx.sv
// Buffered packet source for the router input port: loads a full payload, then
// bursts header/payload/parity. Optional PKT_TX_PAR_INJECT_EN adds inj_par to force bad parity.
module router_pkt_tx #(
  parameter int GAP_CYC   = 2,
  parameter int ERR_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
`ifdef PKT_TX_PAR_INJECT_EN
  input  logic                 inj_par,
`endif
  input  logic                 req_valid,
  input  logic [1:0]           req_addr,
  input  logic [5:0]           req_len,
  output logic                 req_ready,
  input  logic                 pld_valid,
  input  logic [7:0]           pld_data,
  output logic                 pld_ready,
  input  logic                 busy,
  input  logic                 err,
  output logic [7:0]           data_out,
  output logic                 pkt_valid,
  output logic                 pkt_done,
  output logic                 req_err,
  output logic [ERR_CNT_W-1:0] err_cnt
);

  typedef enum logic [2:0] {IDLE, LOAD, HDR, PLD, PAR, GAP} state_t;

  localparam logic [3:0] GAP_LAST = 4'(GAP_CYC - 1);

  state_t               state_reg;
  logic [1:0]           addr_reg;
  logic [5:0]           len_reg;
  logic [7:0]           par_reg;
  logic [5:0]           wptr_reg;
  logic [5:0]           rptr_reg;
  logic [3:0]           gap_cnt_reg;
  logic                 err_seen_reg;
  logic                 inj_reg;
  logic [7:0]           data_out_reg;
  logic                 pkt_valid_reg;
  logic                 pkt_done_reg;
  logic                 req_err_reg;
  logic [ERR_CNT_W-1:0] err_cnt_reg;
  logic [7:0]           mem [0:63];

  logic       req_hs;
  logic       pld_hs;
  logic [7:0] hdr;
  logic [7:0] par_byte;

  assign req_ready = (state_reg == IDLE);
  assign pld_ready = (state_reg == LOAD);
  assign req_hs    = req_valid && req_ready;
  assign pld_hs    = pld_valid && pld_ready;
  assign hdr       = {len_reg, addr_reg};
  assign par_byte  = inj_reg ? ~par_reg : par_reg;

  assign data_out  = data_out_reg;
  assign pkt_valid = pkt_valid_reg;
  assign pkt_done  = pkt_done_reg;
  assign req_err   = req_err_reg;
  assign err_cnt   = err_cnt_reg;

  // Payload buffer: plain array, no reset, read through data_out_reg.
  always_ff @(posedge clk) begin
    if (pld_hs)
      mem[wptr_reg] <= pld_data;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg     <= IDLE;
      addr_reg      <= '0;
      len_reg       <= '0;
      par_reg       <= '0;
      wptr_reg      <= '0;
      rptr_reg      <= '0;
      gap_cnt_reg   <= '0;
      err_seen_reg  <= 1'b0;
      inj_reg       <= 1'b0;
      data_out_reg  <= '0;
      pkt_valid_reg <= 1'b0;
      pkt_done_reg  <= 1'b0;
      req_err_reg   <= 1'b0;
      err_cnt_reg   <= '0;
    end else begin
      req_err_reg  <= 1'b0;
      pkt_done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (req_hs) begin
            if (req_addr == 2'd3 || req_len == 6'd0) begin
              req_err_reg <= 1'b1;
            end else begin
              addr_reg  <= req_addr;
              len_reg   <= req_len;
              par_reg   <= {req_len, req_addr};
              wptr_reg  <= '0;
`ifdef PKT_TX_PAR_INJECT_EN
              inj_reg   <= inj_par;
`else
              inj_reg   <= 1'b0;
`endif
              state_reg <= LOAD;
            end
          end
        end
        LOAD: begin
          if (pld_hs) begin
            par_reg  <= par_reg ^ pld_data;
            wptr_reg <= wptr_reg + 6'd1;
            if (wptr_reg == len_reg - 6'd1) begin
              data_out_reg  <= hdr;
              pkt_valid_reg <= 1'b1;
              state_reg     <= HDR;
            end
          end
        end
        HDR: begin
          if (!busy) begin
            rptr_reg     <= '0;
            data_out_reg <= mem[0];
            state_reg    <= PLD;
          end
        end
        PLD: begin
          if (!busy) begin
            if (rptr_reg == len_reg - 6'd1) begin
              data_out_reg  <= par_byte;
              pkt_valid_reg <= 1'b0;
              state_reg     <= PAR;
            end else begin
              rptr_reg     <= rptr_reg + 6'd1;
              data_out_reg <= mem[rptr_reg + 6'd1];
            end
          end
        end
        PAR: begin
          if (!busy) begin
            data_out_reg <= '0;
            gap_cnt_reg  <= '0;
            err_seen_reg <= 1'b0;
            pkt_done_reg <= (GAP_LAST == 4'd0);
            state_reg    <= GAP;
          end
        end
        GAP: begin
          // err is accumulated across the whole gap and counted once per packet.
          if (gap_cnt_reg == GAP_LAST) begin
            if ((err_seen_reg || err) && !(&err_cnt_reg))
              err_cnt_reg <= err_cnt_reg + 1'b1;
            state_reg <= IDLE;
          end else begin
            err_seen_reg <= err_seen_reg | err;
            gap_cnt_reg  <= gap_cnt_reg + 4'd1;
            pkt_done_reg <= (gap_cnt_reg + 4'd1 == GAP_LAST);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx (GAP_CYC=2, ERR_CNT_W=8).
module tb_router_pkt_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       inj_par;
  logic       req_valid;
  logic [1:0] req_addr;
  logic [5:0] req_len;
  logic       req_ready;
  logic       pld_valid;
  logic [7:0] pld_data;
  logic       pld_ready;
  logic       busy;
  logic       err;
  logic [7:0] data_out;
  logic       pkt_valid;
  logic       pkt_done;
  logic       req_err;
  logic [7:0] err_cnt;

  int checks = 0;
  int errors = 0;
  logic [7:0] pl [0:62];

  always #5 clk = ~clk;

  router_pkt_tx #(.GAP_CYC(2), .ERR_CNT_W(8)) dut (
    .clk(clk), .rst(rst),
`ifdef PKT_TX_PAR_INJECT_EN
    .inj_par(inj_par),
`endif
    .req_valid(req_valid), .req_addr(req_addr), .req_len(req_len), .req_ready(req_ready),
    .pld_valid(pld_valid), .pld_data(pld_data), .pld_ready(pld_ready),
    .busy(busy), .err(err), .data_out(data_out), .pkt_valid(pkt_valid),
    .pkt_done(pkt_done), .req_err(req_err), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // One len=1 packet to port 2; e_out drives err outside GAP, e_gap inside GAP.
  task automatic pkt1(input logic [7:0] d, input logic e_gap, input logic e_out, input logic inj);
    logic [7:0] p;
    p = 8'h06 ^ d;
    if (inj) p = ~p;
    err = e_out; inj_par = inj;
    req_valid = 1'b1; req_addr = 2'd2; req_len = 6'd1;
    cyc();
    req_valid = 1'b0; pld_valid = 1'b1; pld_data = d;
    cyc();
    pld_valid = 1'b0;
    chk("p1_hdr", data_out, 8'h06);
    cyc();
    chk("p1_pld", data_out, d);
    cyc();
    chk("p1_par", {pkt_valid, data_out}, {1'b0, p});
    cyc();
    err = e_gap;
    chk("p1_gap1_done", pkt_done, 1'b0);
    cyc();
    chk("p1_gap2_done", pkt_done, 1'b1);
    cyc();
    err = 1'b0;
    chk("p1_idle", {req_ready, pkt_done}, 2'b10);
  endtask

  initial begin
    logic [7:0] p;
    rst = 1'b0; inj_par = 1'b0; req_valid = 1'b0; req_addr = '0; req_len = '0;
    pld_valid = 1'b0; pld_data = '0; busy = 1'b0; err = 1'b0;
    cyc(); cyc();
    rst = 1'b1;
    chk("rst_req_ready", req_ready, 1'b1);
    chk("rst_pld_ready", pld_ready, 1'b0);
    chk("rst_outs", {pkt_valid, pkt_done, req_err, data_out}, 11'd0);
    chk("rst_err_cnt", err_cnt, 8'd0);

    // Basic packet: addr=1 len=3 A0 B1 C2
    req_valid = 1'b1; req_addr = 2'd1; req_len = 6'd3;
    cyc();
    req_valid = 1'b0;
    chk("t1_load_rdy", {req_ready, pld_ready}, 2'b01);
    pld_valid = 1'b1; pld_data = 8'hA0; cyc();
    pld_data = 8'hB1; cyc();
    pld_data = 8'hC2; cyc();
    pld_valid = 1'b0;
    chk("t1_hdr", {pkt_valid, data_out}, 9'h10D);
    chk("t1_hdr_pldrdy", pld_ready, 1'b0);
    cyc(); chk("t1_b0", {pkt_valid, data_out}, 9'h1A0);
    cyc(); chk("t1_b1", {pkt_valid, data_out}, 9'h1B1);
    cyc(); chk("t1_b2", {pkt_valid, data_out}, 9'h1C2);
    cyc(); chk("t1_par", {pkt_valid, data_out}, 9'h0DE);
    cyc(); chk("t1_gap1", {pkt_valid, pkt_done, data_out}, 10'd0);
    chk("t1_gap1_rdy", req_ready, 1'b0);
    cyc(); chk("t1_gap2_done", pkt_done, 1'b1);
    chk("t1_gap2_rdy", req_ready, 1'b0);
    cyc(); chk("t1_idle", {req_ready, pkt_done}, 2'b10);

    // Same packet with busy stalls on header, B1 and parity
    req_valid = 1'b1; req_addr = 2'd1; req_len = 6'd3;
    cyc();
    req_valid = 1'b0; pld_valid = 1'b1;
    pld_data = 8'hA0; cyc();
    pld_data = 8'hB1; cyc();
    pld_data = 8'hC2; cyc();
    pld_valid = 1'b0; busy = 1'b1;
    cyc(); chk("t2_hdr_hold", {pkt_valid, data_out}, 9'h10D);
    busy = 1'b0;
    cyc(); chk("t2_b0", {pkt_valid, data_out}, 9'h1A0);
    cyc(); chk("t2_b1", {pkt_valid, data_out}, 9'h1B1);
    busy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(); chk("t2_b1_hold", {pkt_valid, data_out}, 9'h1B1);
    end
    busy = 1'b0;
    cyc(); chk("t2_b2", {pkt_valid, data_out}, 9'h1C2);
    cyc(); chk("t2_par", {pkt_valid, data_out}, 9'h0DE);
    busy = 1'b1;
    cyc(); chk("t2_par_hold", {pkt_valid, data_out}, 9'h0DE);
    busy = 1'b0;
    cyc(); cyc();
    chk("t2_done", pkt_done, 1'b1);
    cyc();

    // Illegal requests
    req_valid = 1'b1; req_addr = 2'd3; req_len = 6'd5;
    cyc();
    chk("t3_err1", req_err, 1'b1);
    chk("t3_err1_st", {req_ready, pld_ready, pkt_valid}, 3'b100);
    req_addr = 2'd0; req_len = 6'd0;
    cyc();
    chk("t3_err2", req_err, 1'b1);
    chk("t3_err2_st", {req_ready, pld_ready, pkt_valid}, 3'b100);
    req_valid = 1'b0;
    cyc();
    chk("t3_err_clr", {req_err, pld_ready, pkt_valid}, 3'b000);

    // len=63 with pld_valid toggling
    p = 8'hFE;
    for (int i = 0; i < 63; i++) begin
      pl[i] = 8'(i * 7 + 3);
      p = p ^ pl[i];
    end
    req_valid = 1'b1; req_addr = 2'd2; req_len = 6'd63;
    cyc();
    req_valid = 1'b0;
    for (int k = 0; k < 125; k++) begin
      pld_valid = (k % 2 == 0);
      pld_data = pl[k / 2];
      if (k == 124) chk("t4_load_rdy", pld_ready, 1'b1);
      cyc();
      if (k == 123) chk("t4_load_busy", pkt_valid, 1'b0);
    end
    pld_valid = 1'b0;
    chk("t4_hdr", {pkt_valid, data_out}, 9'h1FE);
    for (int i = 0; i < 63; i++) begin
      cyc();
      chk("t4_burst", {pkt_valid, data_out}, {1'b1, pl[i]});
    end
    cyc(); chk("t4_par", {pkt_valid, data_out}, {1'b0, p});
    cyc(); cyc(); cyc();

    // err counting and saturation
    pkt1(8'h11, 1'b1, 1'b0, 1'b0);
    pkt1(8'h22, 1'b0, 1'b1, 1'b0);
    chk("t5_err_outside", err_cnt, 8'd1);
    pkt1(8'h33, 1'b1, 1'b0, 1'b0);
    pkt1(8'h44, 1'b1, 1'b0, 1'b0);
    chk("t5_err3", err_cnt, 8'd3);
    for (int i = 0; i < 252; i++) pkt1(8'(i), 1'b1, 1'b0, 1'b0);
    chk("t5_err255", err_cnt, 8'd255);
    for (int i = 0; i < 4; i++) pkt1(8'h5A, 1'b1, 1'b0, 1'b0);
    chk("t5_sat", err_cnt, 8'd255);

    // Reset mid-PLD
    req_valid = 1'b1; req_addr = 2'd1; req_len = 6'd3;
    cyc();
    req_valid = 1'b0; pld_valid = 1'b1;
    pld_data = 8'hA0; cyc();
    pld_data = 8'hB1; cyc();
    pld_data = 8'hC2; cyc();
    pld_valid = 1'b0;
    cyc(); chk("t6_in_pld", {pkt_valid, data_out}, 9'h1A0);
    rst = 1'b0;
    cyc();
    rst = 1'b1;
    chk("t6_rst_outs", {pkt_valid, data_out}, 9'h000);
    chk("t6_rst_state", {req_ready, pld_ready}, 2'b10);
    chk("t6_rst_errcnt", err_cnt, 8'd0);
    pkt1(8'h77, 1'b0, 1'b0, 1'b0);
    chk("t6_errcnt_after", err_cnt, 8'd0);
`ifdef PKT_TX_PAR_INJECT_EN
    pkt1(8'h77, 1'b0, 1'b0, 1'b1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
